// File: rtl/demux_4_buf_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer.
package demux_4_buf_pkg;

  // Number of output channels served by the demultiplexer.
  localparam int CHANNELS = 4;

  // Buffer occupancy: EMPTY (nothing held), BUSY (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    STATE_EMPTY = 2'd0,
    STATE_BUSY  = 2'd1,
    STATE_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/demux_4_buf_hold_reg.sv
// Width-parameterised storage register with load, clear and async active-low reset.
module hold_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Load takes priority over clear so a simultaneous refill is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/demux_4_buf.sv
// Registered 1-to-4 demultiplexer with a main/skid buffer and valid/ready handshakes.
module demux_4_buf
  import demux_4_buf_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] data_in,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] data_out_0,
  output logic [width-1:0] data_out_1,
  output logic [width-1:0] data_out_2,
  output logic [width-1:0] data_out_3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  // Each buffer entry is packed as {valid, select, data}.
  localparam int ENTRY_W = width + 3;

  state_t state, next_state;

  logic [ENTRY_W-1:0] main_q, main_d, skid_q, skid_d, in_entry;
  logic               main_load, main_clear, skid_load, skid_clear;
  logic               main_valid;
  logic [1:0]         main_sel;
  logic [width-1:0]   main_data;
  logic               in_fire, out_fire;

  assign in_entry   = {1'b1, select, data_in};
  assign main_valid = main_q[ENTRY_W-1];
  assign main_sel   = main_q[width+1:width];
  assign main_data  = main_q[width-1:0];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready[main_sel];

  hold_reg #(.width(ENTRY_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_d),
    .q       (main_q)
  );

  hold_reg #(.width(ENTRY_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (skid_d),
    .q       (skid_q)
  );

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STATE_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // in_ready is registered: it is low exactly when the buffer will be full next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (next_state != STATE_FULL);
    end
  end

  // Next-state and buffer steering: new words land in main unless main is stuck, then in skid.
  always_comb begin
    next_state = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_entry;
    skid_d     = in_entry;
    case (state)
      STATE_EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          next_state = STATE_BUSY;
        end
      end
      STATE_BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          next_state = STATE_FULL;
        end else if (out_fire) begin
          main_clear = 1'b1;
          next_state = STATE_EMPTY;
        end
      end
      STATE_FULL: begin
        if (out_fire) begin
          main_d     = skid_q;
          main_load  = 1'b1;
          skid_clear = 1'b1;
          next_state = STATE_BUSY;
        end
      end
      default: begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
        next_state = STATE_EMPTY;
      end
    endcase
  end

  // Channel valids decode straight from the main register, never from inputs.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      out_valid[k] = main_valid && (main_sel == 2'(k));
    end
  end

  assign data_out_0 = out_valid[0] ? main_data : '0;
  assign data_out_1 = out_valid[1] ? main_data : '0;
  assign data_out_2 = out_valid[2] ? main_data : '0;
  assign data_out_3 = out_valid[3] ? main_data : '0;

endmodule

// File: tb/tb_demux_4_buf.sv
// Scoreboard testbench for demux_4_buf: words in order, at most two buffered.
module tb_demux_4_buf;

  logic        clk;
  logic        reset_n;
  logic [31:0] data_in;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } word_t;

  word_t       sb_q[$];
  bit          exp_ready;
  int          compared;
  int          mismatched;
  logic [31:0] dout [4];

  demux_4_buf #(.width(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;
  assign dout[3] = data_out_3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the queue head, pop on a handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      exp_ready = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 4; k++) check($sformatf("rst_data_out_%0d", k), dout[k], 32'd0);
    end else begin
      logic [3:0] ev;
      exp_ready = (sb_q.size() < 2);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      ev = (sb_q.size() > 0) ? (4'b0001 << sb_q[0].sel) : 4'b0000;
      check("out_valid", 32'(out_valid), 32'(ev));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("data_out_%0d", k), dout[k], ev[k] ? sb_q[0].data : 32'd0);
      end
      if (sb_q.size() > 0 && out_ready[sb_q[0].sel]) void'(sb_q.pop_front());
    end
  end

  // One cycle of stimulus; an accepted word is pushed to the scoreboard.
  task automatic apply_stimulus(input bit v, input logic [31:0] d, input logic [1:0] s,
                                input logic [3:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    data_in   = d;
    select    = s;
    out_ready = r;
    @(negedge clk);
    #1;
    if (reset_n && v && exp_ready) sb_q.push_back('{sel: s, data: d});
  endtask

  // Pulse reset between edges and check the immediate asynchronous clear.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_valid", 32'(out_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ready  = 1'b1;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    data_in    = 32'hDEADBEEF;
    select     = 2'd2;
    out_ready  = 4'b1111;

    // Reset held with a live input: nothing may be captured.
    repeat (3) apply_stimulus(1'b1, 32'hDEADBEEF, 2'd2, 4'b1111);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (2) apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    // Single route to channel 3.
    apply_stimulus(1'b1, 32'd1234, 2'd3, 4'b1111);
    repeat (2) apply_stimulus(1'b0, 32'hFFFF_FFFF, 2'd1, 4'b1111);

    // Streaming across all channels.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'(10 * (i + 1)), 2'(i), 4'b1111);
    repeat (2) apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    // Backpressure fills main and skid, then drains in order.
    apply_stimulus(1'b1, 32'd5, 2'd1, 4'b0000);
    apply_stimulus(1'b1, 32'd6, 2'd2, 4'b0000);
    repeat (3) apply_stimulus(1'b1, 32'd99, 2'd0, 4'b0000);
    apply_stimulus(1'b0, 32'h0, 2'd0, 4'b0010);
    apply_stimulus(1'b0, 32'h0, 2'd0, 4'b0010);
    apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);
    apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    // Ready on other channels must not release a channel-0 word.
    apply_stimulus(1'b1, 32'd7, 2'd0, 4'b1110);
    repeat (4) apply_stimulus(1'b0, 32'h0, 2'd3, 4'b1110);
    repeat (2) apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    // Mid-operation reset from FULL.
    apply_stimulus(1'b1, 32'hA1, 2'd1, 4'b0000);
    apply_stimulus(1'b1, 32'hA2, 2'd3, 4'b0000);
    pulse_reset();
    repeat (3) apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom),
                     4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0000));
    end
    repeat (4) apply_stimulus(1'b0, 32'h0, 2'd0, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_4_buf.md
Name: demux_4_buf

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshaking; the inverse of the 4-input mux.
- Accepts one data word plus a 2-bit destination select per transfer and presents it on the selected one of four output channels.
- Sits between a single producer (e.g. writeback/result bus) and four consumers (register file ports, memory write path, etc.).
- Two-entry buffering (main + skid) sustains one transfer per cycle and registers in_ready.

Parameters:
- width, 32, data word width in bits (>= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  width  input data word
- select  input  2  destination channel (0..3) for data_in
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word (registered)
- data_out_0..data_out_3  output  width each  per-channel output data
- out_valid  output  4  bit k: channel k holds a valid word
- out_ready  input  4  bit k: consumer k accepts the word

Behaviour:
- Single clock domain on clk. Reset is asynchronous, active-low on reset_n, with no synchronous reset.
- Reset values:
  - in_ready = 1.
  - out_valid = 4'b0000.
  - data_out_0..3 = 0.
  - Main and skid registers (data, select, valid) all cleared.
- Input fire = in_valid && in_ready. Output fire = out_valid[main_sel] && out_ready[main_sel].
- out_ready bits for non-selected channels are ignored.
- Outputs (all driven from registers only, no input-to-output combinational path):
  - out_valid[k] = main_valid && (main_sel == k).
  - data_out_k = main_data when out_valid[k], else 0.
- State machine:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: both valid.
  - in_ready = (next state != FULL), registered.
- Transitions from EMPTY:
  - Input fire -> BUSY; main <= {data_in, select}.
- Transitions from BUSY:
  - Input fire and output fire -> BUSY; main <= input.
  - Input fire only -> FULL; skid <= input.
  - Output fire only -> EMPTY.
  - Neither -> BUSY, hold.
- Transitions from FULL:
  - in_ready = 0, so no input fire.
  - Output fire -> BUSY; main <= skid; skid cleared.
  - No output fire -> hold.
- Latency: a word accepted at edge N appears on out_valid after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle while the selected consumer is ready.
- Ordering: strictly in order across all channels. A stalled channel blocks subsequent words to other channels (head-of-line blocking is intended).
- Held data: when out_valid[k] = 1 and out_ready[k] = 0, data_out_k and out_valid remain stable until fire.
- Consecutive words to the same channel: out_valid[k] stays high and data_out_k updates each fire.
- Word-count invariant: no word is dropped or duplicated. The number of output fires equals the number of input fires minus the words held.
- Reset asserted mid-operation immediately clears all buffered words, with no output fire. Release synchronises to the next rising edge.
- When in_valid = 0, data_in and select are don't-care and must not affect state.

Decomposition:
- Shared include file holds:
  - state encoding localparams: STATE_EMPTY = 2'd0, STATE_BUSY = 2'd1, STATE_FULL = 2'd2;
  - channel count localparam CHANNELS = 4.
- One natural sub-module: hold_reg, a width-parameterised register with load enable, clear, and async active-low reset.
  - Instantiated for main and skid entries, storing {valid, select, data}.

Test Plan:
- Reset: hold reset_n = 0 with in_valid = 1, data_in = 32'hDEADBEEF, select = 2 -> in_ready = 1, out_valid = 0, all data_out = 0, no capture.
- Single route: data_in = 1234, select = 3, one cycle, out_ready = 4'b1111 -> next cycle out_valid = 4'b1000, data_out_3 = 1234, others 0; then out_valid = 0.
- Streaming: words 10, 20, 30, 40 with selects 0, 1, 2, 3 on back-to-back cycles, out_ready = 4'b1111 -> out_valid walks 0001, 0010, 0100, 1000 on consecutive cycles; in_ready never drops.
- Backpressure: out_ready = 0, send 5 (sel 1) then 6 (sel 2) -> after second accept in_ready = 0; data_out_1 = 5 held.
  - Raise out_ready[1] -> 5 fires, then out_valid = 4'b0100 with data_out_2 = 6, and in_ready = 1.
- Non-selected ready ignored: word 7 to channel 0 with out_ready = 4'b1110 -> word stays on channel 0 indefinitely with no fire.
- Mid-operation reset: in FULL state pulse reset_n low for 3 ns between edges -> out_valid = 0 and in_ready = 1 immediately; no stale word after release.
